// File: rtl/l2_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_ctrl
// Brief    : Fixed-latency line-burst memory endpoint behind the L2 cache.
// Revision : 1.0 - initial release
// ============================================================================
module l2_mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int LATENCY   = 8,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l2_stb,
    input  logic              l2_we,
    input  logic [ADDR_W-1:0] l2_addr,
    output logic              l2_rdy,
    input  logic              l2_wvalid,
    input  logic [DATA_W-1:0] l2_wdata,
    output logic              l2_wready,
    output logic              l2_rvalid,
    output logic [DATA_W-1:0] l2_rdata,
    output logic              l2_rlast,
    output logic              l2_ack
);

    localparam int c_offW  = $clog2(BURST_LEN * 8);
    localparam int c_beatW = $clog2(BURST_LEN);
    localparam int c_memAw = $clog2(MEM_WORDS);
    localparam int c_lineW = c_memAw - c_beatW;
    localparam int c_latW  = $clog2(LATENCY + 1);
    localparam logic [c_beatW-1:0] c_lastBeat = c_beatW'(BURST_LEN - 1);
    localparam logic [c_latW-1:0]  c_latInit  = c_latW'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        WAIT   = 3'd2,
        RBURST = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              r_state, w_nextState;
    logic [c_beatW-1:0]  r_beatCnt, w_nextBeat, w_rdBeat;
    logic [c_latW-1:0]   r_latCnt, w_nextLat;
    logic [c_lineW-1:0]  r_line;
    logic                r_we;
    logic                r_wready, r_rvalid, r_rlast, r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_nextWready, w_nextRvalid, w_nextRlast, w_nextAck;
    logic                w_memWe, w_latch;
    logic [c_memAw-1:0]  w_wrIdx, w_rdIdx;
    logic [DATA_W-1:0]   w_rdWord;
    logic                w_unusedAddr;

    logic [DATA_W-1:0]   r_mem [MEM_WORDS];

    // Only the line bits that land inside the store are kept; the rest alias.
    assign w_unusedAddr = ^l2_addr;
    assign w_wrIdx      = {r_line, r_beatCnt};
    assign w_rdIdx      = {r_line, w_rdBeat};
    assign w_rdWord     = r_mem[w_rdIdx];

    always_comb begin
        w_nextState  = r_state;
        w_nextBeat   = r_beatCnt;
        w_nextLat    = r_latCnt;
        w_nextWready = 1'b0;
        w_nextRvalid = 1'b0;
        w_nextRlast  = 1'b0;
        w_nextAck    = 1'b0;
        w_rdBeat     = r_beatCnt;
        w_memWe      = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            IDLE: begin
                if (l2_stb) begin
                    w_latch    = 1'b1;
                    w_nextBeat = '0;
                    if (l2_we) begin
                        w_nextState  = WDATA;
                        w_nextWready = 1'b1;
                    end else begin
                        w_nextState = WAIT;
                        w_nextLat   = c_latInit;
                    end
                end
            end
            WDATA: begin
                w_nextWready = 1'b1;
                if (l2_wvalid) begin
                    w_memWe    = 1'b1;
                    w_nextBeat = r_beatCnt + c_beatW'(1);
                    if (r_beatCnt == c_lastBeat) begin
                        w_nextState  = WAIT;
                        w_nextLat    = c_latInit;
                        w_nextWready = 1'b0;
                        w_nextBeat   = '0;
                    end
                end
            end
            WAIT: begin
                if (r_latCnt == '0) begin
                    if (r_we) begin
                        w_nextState = DONE;
                        w_nextAck   = 1'b1;
                    end else begin
                        // Outputs are registered, so beat 0 is fetched on the way in.
                        w_nextState  = RBURST;
                        w_nextRvalid = 1'b1;
                    end
                end else begin
                    w_nextLat = r_latCnt - c_latW'(1);
                end
            end
            RBURST: begin
                if (r_beatCnt == c_lastBeat) begin
                    w_nextState = IDLE;
                    w_nextBeat  = '0;
                end else begin
                    w_nextBeat   = r_beatCnt + c_beatW'(1);
                    w_rdBeat     = w_nextBeat;
                    w_nextRvalid = 1'b1;
                    w_nextRlast  = (w_nextBeat == c_lastBeat);
                    w_nextAck    = (w_nextBeat == c_lastBeat);
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_beatCnt <= '0;
            r_latCnt  <= '0;
            r_line    <= '0;
            r_we      <= 1'b0;
            r_wready  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_beatCnt <= w_nextBeat;
            r_latCnt  <= w_nextLat;
            r_wready  <= w_nextWready;
            r_rvalid  <= w_nextRvalid;
            r_rlast   <= w_nextRlast;
            r_ack     <= w_nextAck;
            if (w_latch) begin
                r_line <= l2_addr[c_offW +: c_lineW];
                r_we   <= l2_we;
            end
            if (w_nextRvalid) begin
                r_rdata <= w_rdWord;
            end
        end
    end

    // Backing store deliberately has no reset.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_wrIdx] <= l2_wdata;
        end
    end

    assign l2_rdy    = (r_state == IDLE);
    assign l2_wready = r_wready;
    assign l2_rvalid = r_rvalid;
    assign l2_rdata  = r_rdata;
    assign l2_rlast  = r_rlast;
    assign l2_ack    = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_mem_ctrl
// Brief    : Directed self-checking bench for l2_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_mem_ctrl;

    localparam int LATENCY = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        l2_stb = 1'b0;
    logic        l2_we = 1'b0;
    logic [31:0] l2_addr = '0;
    logic        l2_rdy;
    logic        l2_wvalid = 1'b0;
    logic [63:0] l2_wdata = '0;
    logic        l2_wready;
    logic        l2_rvalid;
    logic [63:0] l2_rdata;
    logic        l2_rlast;
    logic        l2_ack;

    int tests = 0;
    int failed = 0;
    logic [63:0] wbeat [4];
    logic [63:0] rexp  [4];

    l2_mem_ctrl #(
        .ADDR_W(32), .DATA_W(64), .BURST_LEN(4), .LATENCY(LATENCY), .MEM_WORDS(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .l2_stb(l2_stb), .l2_we(l2_we), .l2_addr(l2_addr), .l2_rdy(l2_rdy),
        .l2_wvalid(l2_wvalid), .l2_wdata(l2_wdata), .l2_wready(l2_wready),
        .l2_rvalid(l2_rvalid), .l2_rdata(l2_rdata), .l2_rlast(l2_rlast),
        .l2_ack(l2_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setBeats(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
        wbeat[0] = b0; wbeat[1] = b1; wbeat[2] = b2; wbeat[3] = b3;
    endtask

    // Issue a write-back and deliver its beats; returns just after the last beat edge.
    task automatic writeLine(input logic [31:0] addr, input int gap);
        l2_stb = 1'b1; l2_we = 1'b1; l2_addr = addr;
        tick();
        l2_stb = 1'b0; l2_we = 1'b0;
        check("wr_wready_on", 64'(l2_wready), 64'd1);
        check("wr_rdy_busy", 64'(l2_rdy), 64'd0);
        for (int b = 0; b < 4; b++) begin
            if (b > 0 && gap > 0) begin
                for (int g = 0; g < gap; g++) begin
                    l2_wvalid = 1'b0;
                    tick();
                end
                check("wr_wready_gap", 64'(l2_wready), 64'd1);
            end
            l2_wvalid = 1'b1;
            l2_wdata  = wbeat[b];
            tick();
        end
        l2_wvalid = 1'b0;
        l2_wdata  = '0;
        check("wr_wready_off", 64'(l2_wready), 64'd0);
    endtask

    task automatic waitAck(input int start);
        int n;
        n = start;
        while (l2_ack !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("wr_ack_latency", 64'(n), 64'(LATENCY));
        check("wr_rdy_at_ack", 64'(l2_rdy), 64'd0);
        tick();
        check("wr_ack_pulse", 64'(l2_ack), 64'd0);
        check("wr_rdy_after", 64'(l2_rdy), 64'd1);
    endtask

    task automatic readResp(input int start);
        int n;
        n = start;
        while (l2_rvalid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("rd_latency", 64'(n), 64'(LATENCY));
        for (int b = 0; b < 4; b++) begin
            check("rd_valid", 64'(l2_rvalid), 64'd1);
            check("rd_data", l2_rdata, rexp[b]);
            check("rd_last", 64'(l2_rlast), (b == 3) ? 64'd1 : 64'd0);
            check("rd_ack", 64'(l2_ack), (b == 3) ? 64'd1 : 64'd0);
            tick();
        end
        check("rd_valid_end", 64'(l2_rvalid), 64'd0);
        check("rd_rdy_end", 64'(l2_rdy), 64'd1);
    endtask

    task automatic readLine(input logic [31:0] addr);
        l2_stb = 1'b1; l2_we = 1'b0; l2_addr = addr;
        tick();
        l2_stb = 1'b0;
        check("rd_rdy_busy", 64'(l2_rdy), 64'd0);
        readResp(0);
    endtask

    initial begin
        // Reset asserted between edges must take effect without a clock.
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdy", 64'(l2_rdy), 64'd1);
        check("rst_wready", 64'(l2_wready), 64'd0);
        check("rst_rvalid", 64'(l2_rvalid), 64'd0);
        check("rst_rlast", 64'(l2_rlast), 64'd0);
        check("rst_ack", 64'(l2_ack), 64'd0);
        check("rst_rdata", l2_rdata, 64'd0);
        #9 rst_n = 1'b1;
        tick();

        // Write then read back.
        setBeats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        writeLine(32'h0000_0040, 0);
        waitAck(0);
        rexp = wbeat;
        readLine(32'h0000_0040);

        // Write with two-cycle wvalid gaps.
        setBeats(64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002,
                 64'h5555_0000_0000_0003, 64'h5555_0000_0000_0004);
        writeLine(32'h0000_0040, 2);
        waitAck(0);
        rexp = wbeat;
        readLine(32'h0000_0040);

        // Read strobe pulsed during WAIT is ignored.
        setBeats(64'h6666_6666_0000_0000, 64'h6666_6666_0000_0001,
                 64'h6666_6666_0000_0002, 64'h6666_6666_0000_0003);
        writeLine(32'h0000_0040, 0);
        tick();
        tick();
        l2_stb = 1'b1; l2_we = 1'b0; l2_addr = 32'h0000_0040;
        check("busy_rdy", 64'(l2_rdy), 64'd0);
        tick();
        l2_stb = 1'b0;
        waitAck(3);
        tick();
        check("busy_dropped_rdy", 64'(l2_rdy), 64'd1);
        check("busy_dropped_rvalid", 64'(l2_rvalid), 64'd0);

        // Strobe held through the write is taken in the first IDLE cycle.
        setBeats(64'h7777_0000_7777_0000, 64'h7777_0000_7777_0001,
                 64'h7777_0000_7777_0002, 64'h7777_0000_7777_0003);
        writeLine(32'h0000_0060, 0);
        l2_stb = 1'b1; l2_we = 1'b0; l2_addr = 32'h0000_0060;
        waitAck(0);
        tick();
        l2_stb = 1'b0;
        check("held_accepted", 64'(l2_rdy), 64'd0);
        rexp = wbeat;
        readResp(0);

        // Address aliasing: 0x8040 maps onto the same words as 0x0040.
        setBeats(64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1,
                 64'hC2C2_C2C2_C2C2_C2C2, 64'hD3D3_D3D3_D3D3_D3D3);
        writeLine(32'h0000_8040, 0);
        waitAck(0);
        rexp = wbeat;
        readLine(32'h0000_0040);
        // The neighbouring line written earlier must be untouched.
        setBeats(64'h7777_0000_7777_0000, 64'h7777_0000_7777_0001,
                 64'h7777_0000_7777_0002, 64'h7777_0000_7777_0003);
        rexp = wbeat;
        readLine(32'h0000_0060);

        // Reset during the read burst, with beat 2 on the bus.
        l2_stb = 1'b1; l2_we = 1'b0; l2_addr = 32'h0000_0040;
        tick();
        l2_stb = 1'b0;
        begin
            int n;
            n = 0;
            while (l2_rvalid !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
            check("mid_latency", 64'(n), 64'(LATENCY));
        end
        tick();
        tick();
        check("mid_beat2", l2_rdata, 64'hC2C2_C2C2_C2C2_C2C2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 64'(l2_rvalid), 64'd0);
        check("mid_rst_ack", 64'(l2_ack), 64'd0);
        check("mid_rst_rlast", 64'(l2_rlast), 64'd0);
        check("mid_rst_rdata", l2_rdata, 64'd0);
        check("mid_rst_rdy", 64'(l2_rdy), 64'd1);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_ack", 64'(l2_ack), 64'd0);
        check("post_rst_rvalid", 64'(l2_rvalid), 64'd0);
        setBeats(64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1,
                 64'hC2C2_C2C2_C2C2_C2C2, 64'hD3D3_D3D3_D3D3_D3D3);
        rexp = wbeat;
        readLine(32'h0000_0040);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
